// File: rtl/riscv_serial_div_pkg.sv
// rtl/riscv_serial_div_pkg.sv - ALU divide operator codes, divider state type and helpers
// Operator bit 0 selects signed operation, bit 1 selects remainder instead of quotient.
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_DIVU) || (op == ALU_DIV) || (op == ALU_REMU) || (op == ALU_REM);
  endfunction

  // Two's-complement magnitude; only applied when the operation is signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/riscv_serial_div_if.sv
// rtl/riscv_serial_div_if.sv - EX-stage request/response bundle for the serial divider
// The divider is the slave; the EX stage (or bench) drives the master side.
interface riscv_serial_div_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  enable_i;
  logic [6:0]            operator_i;
  logic [DATA_WIDTH-1:0] op_a_i;
  logic [DATA_WIDTH-1:0] op_b_i;
  logic                  flush_i;
  logic                  ex_ready_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output enable_i, operator_i, op_a_i, op_b_i, flush_i, ex_ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  enable_i, operator_i, op_a_i, op_b_i, flush_i, ex_ready_i,
    output ready_o, valid_o, result_o
  );

endinterface

// File: rtl/riscv_serial_div.sv
// rtl/riscv_serial_div.sv - Radix-2 restoring divider, one quotient bit per cycle
// Divide-by-zero and signed overflow bypass the 32-cycle loop and finish in one cycle.
module riscv_serial_div
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  riscv_serial_div_if.slave   div_if
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  div_state_t   state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [W-1:0] dividend_q, dividend_d;
  logic [W-1:0] divisor_q, divisor_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] result_q, result_d;
  logic         rem_sel_q, rem_sel_d;
  logic         neg_quot_q, neg_quot_d;
  logic         neg_rem_q, neg_rem_d;

  logic [W:0]   partial;
  logic         ge;
  logic [W-1:0] next_rem;
  logic [W-1:0] next_quot;
  logic         op_signed;

  // Partial remainder is kept one bit wider so divisors with bit 31 set still compare correctly.
  assign partial   = {rem_q, dividend_q[W-1]};
  assign ge        = (partial >= {1'b0, divisor_q});
  assign next_rem  = ge ? W'(partial - {1'b0, divisor_q}) : partial[W-1:0];
  assign next_quot = {quot_q[W-2:0], ge};
  assign op_signed = div_if.operator_i[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    result_d   = result_q;
    rem_sel_d  = rem_sel_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (div_if.enable_i && is_div_op(div_if.operator_i)) begin
          rem_sel_d  = div_if.operator_i[1];
          neg_quot_d = op_signed && (div_if.op_a_i[W-1] ^ div_if.op_b_i[W-1]);
          neg_rem_d  = op_signed && div_if.op_a_i[W-1];
          if (div_if.op_b_i == '0) begin
            result_d = div_if.operator_i[1] ? div_if.op_a_i : '1;
            state_d  = DONE;
          end else if (op_signed && (div_if.op_a_i == MIN_NEG) && (div_if.op_b_i == '1)) begin
            result_d = div_if.operator_i[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            dividend_d = abs32(div_if.op_a_i, op_signed);
            divisor_d  = abs32(div_if.op_b_i, op_signed);
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = 5'd31;
            state_d    = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        rem_d      = next_rem;
        quot_d     = next_quot;
        dividend_d = {dividend_q[W-2:0], 1'b0};
        cnt_d      = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          cnt_d   = 5'd0;
          state_d = DONE;
          if (rem_sel_q) result_d = neg_rem_q  ? (~next_rem + 1'b1)  : next_rem;
          else           result_d = neg_quot_q ? (~next_quot + 1'b1) : next_quot;
        end
      end

      DONE: begin
        if (div_if.ex_ready_i) begin
          state_d  = IDLE;
          result_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over any start or handshake in the same cycle.
    if (div_if.flush_i) begin
      state_d    = IDLE;
      cnt_d      = 5'd0;
      dividend_d = '0;
      divisor_d  = '0;
      rem_d      = '0;
      quot_d     = '0;
      result_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      result_q   <= '0;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      result_q   <= result_d;
      rem_sel_q  <= rem_sel_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign div_if.ready_o  = (state_q == IDLE);
  assign div_if.valid_o  = (state_q == DONE);
  assign div_if.result_o = (state_q == DONE) ? result_q : '0;

endmodule
